// File: rtl/btn_conditioner.sv
// Push-button conditioner: 2-flop synchronizer, tick-based debounce of press and
// release, and optional auto-repeat while held. All outputs are registered pulses/levels.
module btn_conditioner #(
   parameter int unsigned DEB_MS        = 10,
   parameter int unsigned REP_DELAY_MS  = 500,
   parameter int unsigned REP_PERIOD_MS = 100
) (
   input  logic clk,
   input  logic R,
   input  logic ce1ms,
   input  logic btn,
   input  logic rep_en,
   output logic level,
   output logic press,
   output logic rpt,
   output logic release_pulse
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      PRESS_DEB = 2'd1,
      HELD      = 2'd2,
      REL_DEB   = 2'd3
   } state_t;

   localparam logic [15:0] DEB_LIM   = 16'(DEB_MS);
   localparam logic [15:0] DELAY_LIM = 16'(REP_DELAY_MS);
   localparam logic [15:0] PERIOD_LIM = 16'(REP_PERIOD_MS);

   state_t      state_r;
   logic        s1_r;
   logic        s2_r;
   logic [15:0] dc_r;
   logic [15:0] rc_r;
   logic        first_r;
   logic [15:0] dc_inc_s;
   logic [15:0] rc_inc_s;
   logic [15:0] rep_lim_s;

   // Two-stage synchronizer for the asynchronous button level
   always_ff @(posedge clk) begin
      if (R) begin
         s1_r <= 1'b0;
         s2_r <= 1'b0;
      end else begin
         s1_r <= btn;
         s2_r <= s1_r;
      end
   end

   // Next counter values and the active repeat limit (first repeat uses the longer delay)
   always_comb begin
      dc_inc_s  = dc_r + 16'd1;
      rc_inc_s  = rc_r + 16'd1;
      rep_lim_s = PERIOD_LIM;
      if (first_r) begin
         rep_lim_s = DELAY_LIM;
      end else begin
         rep_lim_s = PERIOD_LIM;
      end
   end

   // Debounce / repeat FSM with registered outputs; a level change beats a same-clk tick
   always_ff @(posedge clk) begin
      press         <= 1'b0;
      rpt           <= 1'b0;
      release_pulse <= 1'b0;
      if (R) begin
         state_r <= IDLE;
         dc_r    <= 16'd0;
         rc_r    <= 16'd0;
         first_r <= 1'b0;
         level   <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               dc_r <= 16'd0;
               if (s2_r) begin
                  state_r <= PRESS_DEB;
               end
            end
            PRESS_DEB: begin
               if (!s2_r) begin
                  state_r <= IDLE;
                  dc_r    <= 16'd0;
               end else if (ce1ms) begin
                  if (dc_inc_s == DEB_LIM) begin
                     state_r <= HELD;
                     dc_r    <= 16'd0;
                     rc_r    <= 16'd0;
                     first_r <= 1'b1;
                     level   <= 1'b1;
                     press   <= 1'b1;
                     rpt     <= 1'b1;
                  end else begin
                     dc_r <= dc_inc_s;
                  end
               end
            end
            HELD: begin
               if (!s2_r) begin
                  state_r <= REL_DEB;
                  dc_r    <= 16'd0;
               end else if (rep_en && ce1ms) begin
                  if (rc_inc_s == rep_lim_s) begin
                     rpt     <= 1'b1;
                     rc_r    <= 16'd0;
                     first_r <= 1'b0;
                  end else begin
                     rc_r <= rc_inc_s;
                  end
               end
            end
            REL_DEB: begin
               // rc stays frozen here so a bounce resumes the repeat cadence
               if (s2_r) begin
                  state_r <= HELD;
                  dc_r    <= 16'd0;
               end else if (ce1ms) begin
                  if (dc_inc_s == DEB_LIM) begin
                     state_r       <= IDLE;
                     dc_r          <= 16'd0;
                     level         <= 1'b0;
                     release_pulse <= 1'b1;
                  end else begin
                     dc_r <= dc_inc_s;
                  end
               end
            end
            default: begin
               state_r <= IDLE;
               dc_r    <= 16'd0;
               level   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Bench for btn_conditioner: scenario tasks plus randomized stimulus, all checked
// against a stable-run / deadline reference model of the button behaviour.
module tb_btn_conditioner;

   localparam int DEB    = 3;
   localparam int DELAY  = 5;
   localparam int PERIOD = 2;

   logic clk = 1'b0;
   logic R = 1'b1;
   logic ce1ms = 1'b0;
   logic btn = 1'b0;
   logic rep_en = 1'b0;
   logic level, press, rpt, release_pulse;

   int errors = 0;
   int checks = 0;
   int ce_cnt = 0;

   // reference model state
   logic mb1 = 1'b0, mb2 = 1'b0;
   logic m_lvl = 1'b0, m_pend = 1'b0;
   int   m_cnt = 0, m_acc = 0, m_deadline = 0;
   logic m_press = 1'b0, m_rpt = 1'b0, m_rel = 1'b0;

   btn_conditioner #(.DEB_MS(DEB), .REP_DELAY_MS(DELAY), .REP_PERIOD_MS(PERIOD)) dut (
      .clk(clk), .R(R), .ce1ms(ce1ms), .btn(btn), .rep_en(rep_en),
      .level(level), .press(press), .rpt(rpt), .release_pulse(release_pulse)
   );

   always #5 clk = ~clk;

   // Model: a level is accepted after DEB ticks of continuous disagreement (the first
   // disagreeing clk only opens the run); repeats fire at absolute held-tick deadlines.
   task automatic model_update();
      logic s2;
      m_press = 1'b0; m_rpt = 1'b0; m_rel = 1'b0;
      if (R) begin
         mb1 = 1'b0; mb2 = 1'b0; m_lvl = 1'b0; m_pend = 1'b0; m_cnt = 0;
      end else begin
         s2 = mb2; mb2 = mb1; mb1 = btn;
         if (s2 == m_lvl) begin
            if (m_lvl && !m_pend && ce1ms && rep_en) begin
               m_acc++;
               if (m_acc == m_deadline) begin
                  m_rpt = 1'b1;
                  m_deadline += PERIOD;
               end
            end
            m_pend = 1'b0;
         end else if (!m_pend) begin
            m_pend = 1'b1;
            m_cnt = 0;
         end else if (ce1ms) begin
            m_cnt++;
            if (m_cnt == DEB) begin
               m_lvl = !m_lvl;
               m_pend = 1'b0;
               if (m_lvl) begin
                  m_press = 1'b1; m_rpt = 1'b1; m_acc = 0; m_deadline = DELAY;
               end else begin
                  m_rel = 1'b1;
               end
            end
         end
      end
   endtask

   task automatic step(input logic b, input logic en, input logic rst);
      btn = b; rep_en = en; R = rst;
      ce1ms = (ce_cnt == 3);
      ce_cnt = (ce_cnt + 1) % 4;
      @(posedge clk);
      model_update();
      @(negedge clk);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b1, 1'b1);
         checks++;
         if ({level, press, rpt, release_pulse} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_outputs cyc=%0d got=%b exp=0000", i, {level, press, rpt, release_pulse});
         end
      end
   endtask

   task automatic test_press_no_repeat();
      int np = 0, nr = 0;
      for (int i = 0; i < 40; i++) begin
         step(1'b1, 1'b0, 1'b0);
         np += int'(press); nr += int'(rpt);
         checks++;
         if ({level, press, rpt, release_pulse} !== {m_lvl, m_press, m_rpt, m_rel}) begin
            errors++;
            $display("FAIL press_model cyc=%0d got=%b exp=%b", i, {level, press, rpt, release_pulse}, {m_lvl, m_press, m_rpt, m_rel});
         end
      end
      checks++;
      if (np !== 1 || nr !== 1 || level !== 1'b1) begin
         errors++;
         $display("FAIL press_once press=%0d rpt=%0d level=%b exp 1 1 1", np, nr, level);
      end
   endtask

   task automatic test_release_and_repress();
      int nrel = 0, np = 0;
      for (int i = 0; i < 24; i++) begin
         step(1'b0, 1'b0, 1'b0);
         nrel += int'(release_pulse);
         checks++;
         if ({level, press, rpt, release_pulse} !== {m_lvl, m_press, m_rpt, m_rel}) begin
            errors++;
            $display("FAIL release_model cyc=%0d got=%b exp=%b", i, {level, press, rpt, release_pulse}, {m_lvl, m_press, m_rpt, m_rel});
         end
      end
      checks++;
      if (nrel !== 1 || level !== 1'b0) begin
         errors++;
         $display("FAIL release_once release=%0d level=%b exp 1 0", nrel, level);
      end
      for (int i = 0; i < 24; i++) begin
         step(1'b1, 1'b0, 1'b0);
         np += int'(press);
         checks++;
         if (press && release_pulse) begin
            errors++;
            $display("FAIL press_release_overlap cyc=%0d", i);
         end
      end
      checks++;
      if (np !== 1 || level !== 1'b1) begin
         errors++;
         $display("FAIL repress press=%0d level=%b exp 1 1", np, level);
      end
   endtask

   task automatic test_repeat_cadence();
      int idx = 0;
      int got[$];
      int exp_t[7] = '{0, 5, 7, 9, 11, 13, 15};
      bit seen = 0;
      for (int i = 0; i < 24; i++) step(1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 60 && !seen; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (press) begin seen = 1; got.push_back(0); end
      end
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL repeat_press_timeout got=no_press exp=press");
      end
      for (int i = 0; i < 200 && idx < 15; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (ce1ms) idx++;
         if (rpt) got.push_back(idx);
         checks++;
         if ({level, press, rpt, release_pulse} !== {m_lvl, m_press, m_rpt, m_rel}) begin
            errors++;
            $display("FAIL repeat_model tick=%0d got=%b exp=%b", idx, {level, press, rpt, release_pulse}, {m_lvl, m_press, m_rpt, m_rel});
         end
      end
      checks++;
      if (got.size() !== 7) begin
         errors++;
         $display("FAIL repeat_count got=%0d exp=7", got.size());
      end else begin
         for (int k = 0; k < 7; k++) begin
            checks++;
            if (got[k] !== exp_t[k]) begin
               errors++;
               $display("FAIL repeat_tick[%0d] got=%0d exp=%0d", k, got[k], exp_t[k]);
            end
         end
      end
   endtask

   task automatic test_held_glitch();
      bit bad = 0, seen = 0;
      for (int i = 0; i < 16; i++) begin
         step((i < 4) ? 1'b0 : 1'b1, 1'b1, 1'b0);
         if (press || release_pulse || !level) bad = 1;
         if (rpt) seen = 1;
         checks++;
         if ({level, press, rpt, release_pulse} !== {m_lvl, m_press, m_rpt, m_rel}) begin
            errors++;
            $display("FAIL glitch_model cyc=%0d got=%b exp=%b", i, {level, press, rpt, release_pulse}, {m_lvl, m_press, m_rpt, m_rel});
         end
      end
      for (int i = 0; i < 40 && !seen; i++) begin
         step(1'b1, 1'b1, 1'b0);
         if (rpt) seen = 1;
      end
      checks++;
      if (bad || !seen) begin
         errors++;
         $display("FAIL held_glitch disturbed=%0d rpt_after=%0d exp 0 1", bad, seen);
      end
   endtask

   task automatic test_glitch_reject();
      bit hi = 0;
      for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 24; i++) begin
         step((i < 8) ? 1'b1 : 1'b0, 1'b0, 1'b0);
         if (level || press || rpt) hi = 1;
         checks++;
         if ({level, press, rpt, release_pulse} !== {m_lvl, m_press, m_rpt, m_rel}) begin
            errors++;
            $display("FAIL reject_model cyc=%0d got=%b exp=%b", i, {level, press, rpt, release_pulse}, {m_lvl, m_press, m_rpt, m_rel});
         end
      end
      checks++;
      if (hi) begin
         errors++;
         $display("FAIL glitch_reject got=accepted exp=rejected");
      end
   endtask

   task automatic test_reset_mid_held();
      int nrel = 0, lat = -1;
      for (int i = 0; i < 30; i++) step(1'b1, 1'b1, 1'b0);
      checks++;
      if (level !== 1'b1) begin
         errors++;
         $display("FAIL pre_reset_level got=%b exp=1", level);
      end
      step(1'b1, 1'b1, 1'b1);
      checks++;
      if ({level, press, rpt, release_pulse} !== 4'b0000) begin
         errors++;
         $display("FAIL mid_reset_outputs got=%b exp=0000", {level, press, rpt, release_pulse});
      end
      for (int i = 0; i < 40 && lat < 0; i++) begin
         step(1'b1, 1'b1, 1'b0);
         nrel += int'(release_pulse);
         if (press) lat = i + 1;
         checks++;
         if ({level, press, rpt, release_pulse} !== {m_lvl, m_press, m_rpt, m_rel}) begin
            errors++;
            $display("FAIL post_reset_model cyc=%0d got=%b exp=%b", i, {level, press, rpt, release_pulse}, {m_lvl, m_press, m_rpt, m_rel});
         end
      end
      checks++;
      if (nrel !== 0 || lat < 2 + 4 * (DEB - 1)) begin
         errors++;
         $display("FAIL reset_repress release=%0d latency=%0d exp 0 and >=%0d", nrel, lat, 2 + 4 * (DEB - 1));
      end
   endtask

   task automatic test_random();
      logic b = 1'b0, en = 1'b1;
      int run = 0;
      for (int i = 0; i < 1500; i++) begin
         if (run == 0) begin
            b = ~b;
            run = $urandom_range(30, 1);
            if ($urandom_range(7, 0) == 0) en = ~en;
         end
         run--;
         step(b, en, ($urandom_range(199, 0) == 0) ? 1'b1 : 1'b0);
         checks++;
         if ({level, press, rpt, release_pulse} !== {m_lvl, m_press, m_rpt, m_rel}) begin
            errors++;
            $display("FAIL random_model cyc=%0d got=%b exp=%b", i, {level, press, rpt, release_pulse}, {m_lvl, m_press, m_rpt, m_rel});
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_press_no_repeat();
      test_release_and_repress();
      test_repeat_cadence();
      test_held_glitch();
      test_glitch_reject();
      test_reset_mid_held();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
